// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: drives a 16x2 HD44780-style character LCD bus.
// After reset it waits out the panel power-up time and sends the five
// initialisation commands. It then accepts single command or data bytes
// over a ready/request handshake. For each byte it places RS/DATA on the
// bus, gives the setup time, pulses E, holds, and then waits out the
// execution time before it reports ready again. Clear (0x01) and home
// (0x02) commands get the long execution wait.

module lcd_bus_sequencer #(
    parameter int SETUP_CYC      = 4,
    parameter int EN_HIGH_CYC    = 16,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int POWERUP_CYC    = 750000
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic       iREQ,
    input  logic       iRS,
    input  logic [7:0] iDATA,
    output logic       oREADY,
    output logic       oINIT_DONE,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_E
);

    // The shared down-counter must hold (largest duration - 1).
    localparam int MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > POWERUP_CYC) ? MAX_C : POWERUP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Each state lasts N cycles: the counter is loaded with N-1 on entry
    // and the state is left on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] SETUP_RELOAD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_RELOAD      = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_RELOAD     = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_RELOAD   = CNT_W'(CLEAR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] POWERUP_RELOAD = CNT_W'(POWERUP_CYC - 1);

    localparam logic [2:0] LAST_INIT_IDX = 3'd4;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       idx;
    logic [2:0]       idx_n;
    logic             e_n;
    logic             rs_n;
    logic [7:0]       data_n;
    logic             ready_n;
    logic             done_n;
    logic             cnt_zero;
    logic             long_wait;

    // Power-up initialisation command list.
    function automatic logic [7:0] init_rom(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h0C;
            3'd2:    b = 8'h01;
            3'd3:    b = 8'h06;
            default: b = 8'h80;
        endcase
        return b;
    endfunction

    assign cnt_zero  = (cnt == '0);
    assign long_wait = !oLCD_RS && ((oLCD_DATA == 8'h01) || (oLCD_DATA == 8'h02));
    assign oLCD_RW   = 1'b0;

    // State, counter, init index and all bus outputs are registered here;
    // the async reset also drops E at once if it lands mid-strobe.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= ST_POWERUP;
            cnt        <= POWERUP_RELOAD;
            idx        <= 3'd0;
            oLCD_E     <= 1'b0;
            oLCD_RS    <= 1'b0;
            oLCD_DATA  <= 8'h00;
            oREADY     <= 1'b0;
            oINIT_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            oLCD_E     <= e_n;
            oLCD_RS    <= rs_n;
            oLCD_DATA  <= data_n;
            oREADY     <= ready_n;
            oINIT_DONE <= done_n;
        end
    end

    // Next-state logic; every transition reloads the counter for the new
    // state and computes the next value of each registered output.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_zero ? cnt : cnt - CNT_W'(1);
        idx_n   = idx;
        e_n     = oLCD_E;
        rs_n    = oLCD_RS;
        data_n  = oLCD_DATA;
        ready_n = oREADY;
        done_n  = oINIT_DONE;

        case (state)
            ST_POWERUP: begin
                if (cnt_zero) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end
            end

            ST_LOAD: begin
                rs_n    = 1'b0;
                data_n  = init_rom(idx);
                state_n = ST_SETUP;
                cnt_n   = SETUP_RELOAD;
            end

            ST_SETUP: begin
                if (cnt_zero) begin
                    state_n = ST_STROBE;
                    cnt_n   = EN_RELOAD;
                    e_n     = 1'b1;
                end
            end

            ST_STROBE: begin
                if (cnt_zero) begin
                    state_n = ST_HOLD;
                    cnt_n   = SETUP_RELOAD;
                    e_n     = 1'b0;
                end
            end

            ST_HOLD: begin
                if (cnt_zero) begin
                    state_n = ST_WAIT;
                    cnt_n   = long_wait ? CLEAR_RELOAD : CMD_RELOAD;
                end
            end

            ST_WAIT: begin
                if (cnt_zero) begin
                    if (!oINIT_DONE && (idx < LAST_INIT_IDX)) begin
                        idx_n   = idx + 3'd1;
                        state_n = ST_LOAD;
                        cnt_n   = '0;
                    end else begin
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
            end

            ST_IDLE: begin
                if (iREQ && oREADY) begin
                    rs_n    = iRS;
                    data_n  = iDATA;
                    ready_n = 1'b0;
                    state_n = ST_SETUP;
                    cnt_n   = SETUP_RELOAD;
                end
            end

            default: begin
                state_n = ST_POWERUP;
                cnt_n   = POWERUP_RELOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: scoreboard bench for lcd_bus_sequencer.
// A reference model predicts every E pulse (RS, DATA, rising edge number)
// and the ready/init-done levels from the bus timing rules; a monitor
// compares the DUT's pins against those predictions as pulses appear.

module tb_lcd_bus_sequencer;

    localparam int S     = 2;
    localparam int EN    = 4;
    localparam int CMD_W = 10;
    localparam int CLR_W = 40;
    localparam int PWR   = 100;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       req     = 1'b0;
    logic       rs_in   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    lcd_bus_sequencer #(
        .SETUP_CYC      (S),
        .EN_HIGH_CYC    (EN),
        .CMD_WAIT_CYC   (CMD_W),
        .CLEAR_WAIT_CYC (CLR_W),
        .POWERUP_CYC    (PWR)
    ) dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (rst_n),
        .iREQ       (req),
        .iRS        (rs_in),
        .iDATA      (data_in),
        .oREADY     (ready),
        .oINIT_DONE (init_done),
        .oLCD_DATA  (lcd_data),
        .oLCD_RS    (lcd_rs),
        .oLCD_RW    (lcd_rw),
        .oLCD_E     (lcd_e)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } pulse_t;

    pulse_t     exp_q[$];
    pulse_t     act;
    bit         active;
    bit         prev_e;
    int         cyc;
    int         ready_rise;
    int         accept_count;
    bit         ready_exp;
    bit         done_exp;
    int         checks_total;
    int         checks_passed;
    logic [7:0] init_bytes [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

    function automatic int wait_of(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02)) ? CLR_W : CMD_W;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      name, actual, expected, cyc);
    endtask

    task automatic failEvent(input string name);
        checks_total++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Model reset: edge counting restarts and the five init pulses are
    // scheduled at their predicted rising edges.
    task automatic modelReset();
        int     r;
        int     w;
        pulse_t p;
        exp_q.delete();
        active    = 0;
        prev_e    = 0;
        cyc       = 0;
        ready_exp = 0;
        done_exp  = 0;
        r = PWR + 1 + S;
        for (int k = 0; k < 5; k++) begin
            p.rs   = 1'b0;
            p.data = init_bytes[k];
            p.rise = r;
            exp_q.push_back(p);
            w          = wait_of(1'b0, init_bytes[k]);
            ready_rise = r + EN + S + w;
            r          = r + 1 + 2 * S + EN + w;
        end
    endtask

    // Reference model: counts edges since reset release and decides which
    // requests are accepted and when the sequencer becomes ready again.
    always @(posedge clk) begin
        if (rst_n) begin
            pulse_t p;
            cyc++;
            if (ready_exp && req) begin
                p.rs   = rs_in;
                p.data = data_in;
                p.rise = cyc + S;
                exp_q.push_back(p);
                ready_exp  = 0;
                ready_rise = cyc + 2 * S + EN + wait_of(rs_in, data_in);
                accept_count++;
            end else if (cyc == ready_rise) begin
                ready_exp = 1;
                done_exp  = 1;
            end
        end
    end

    // Monitor: compares handshake levels every cycle and pops the scoreboard
    // on each E rising edge, then follows that pulse through its hold time.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ready", 32'(ready), 32'(ready_exp));
            checkOutput("init_done", 32'(init_done), 32'(done_exp));
            if (!active && exp_q.size() > 0 &&
                cyc >= exp_q[0].rise - S && cyc < exp_q[0].rise) begin
                checkOutput("setup_rs", 32'(lcd_rs), 32'(exp_q[0].rs));
                checkOutput("setup_data", 32'(lcd_data), 32'(exp_q[0].data));
            end
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    failEvent("unexpected_e_pulse");
                end else begin
                    act    = exp_q.pop_front();
                    active = 1;
                    checkOutput("rise_cycle", 32'(cyc), 32'(act.rise));
                    checkOutput("rw", 32'(lcd_rw), 32'd0);
                end
            end else if (!lcd_e && prev_e && active) begin
                checkOutput("fall_cycle", 32'(cyc), 32'(act.rise + EN));
            end
            if (active) begin
                checkOutput("pulse_rs", 32'(lcd_rs), 32'(act.rs));
                checkOutput("pulse_data", 32'(lcd_data), 32'(act.data));
                if (cyc >= act.rise + EN + S - 1) active = 0;
            end
            prev_e = lcd_e;
        end
    end

    // Send one byte; optionally keep iREQ high afterwards for back-to-back.
    task automatic applyStimulus(input logic r, input logic [7:0] d, input bit hold);
        int start;
        int budget;
        start = accept_count;
        @(negedge clk);
        req     = 1'b1;
        rs_in   = r;
        data_in = d;
        budget  = 0;
        while (accept_count == start && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (accept_count == start) failEvent("accept_timeout");
        if (!hold) req = 1'b0;
    endtask

    task automatic waitEHigh();
        int budget;
        budget = 0;
        while (!lcd_e && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!lcd_e) failEvent("e_rise_timeout");
    endtask

    task automatic waitReadyModel();
        int budget;
        budget = 0;
        while (!(ready_exp && exp_q.size() == 0 && !active) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!(ready_exp && exp_q.size() == 0 && !active)) failEvent("ready_timeout");
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_e"}, 32'(lcd_e), 32'd0);
        checkOutput({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        checkOutput({tag, "_data"}, 32'(lcd_data), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
        checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    // Safety net against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic       r;
        logic [7:0] d;
        bit         hold;

        checks_total  = 0;
        checks_passed = 0;
        accept_count  = 0;
        ready_rise    = -1;

        #1 rst_n = 1'b0;
        #1;
        checkResetOutputs("reset");
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Request during power-up must be ignored.
        repeat (20) @(negedge clk);
        req     = 1'b1;
        rs_in   = 1'b1;
        data_in = 8'h55;
        @(negedge clk);
        req = 1'b0;
        waitReadyModel();

        // Single character, then a held clear followed by a character.
        applyStimulus(1'b1, 8'h41, 1'b0);
        waitReadyModel();
        applyStimulus(1'b0, 8'h01, 1'b1);
        applyStimulus(1'b1, 8'h30, 1'b0);
        waitReadyModel();

        // Request mid-strobe of a user byte must be ignored.
        applyStimulus(1'b1, 8'($urandom_range(8'h20, 8'h7e)), 1'b0);
        waitEHigh();
        @(negedge clk);
        req     = 1'b1;
        rs_in   = 1'b1;
        data_in = 8'h99;
        @(negedge clk);
        req = 1'b0;
        waitReadyModel();

        // Sixteen characters back to back.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 8'($urandom_range(8'h20, 8'h7e)), i < 15);
        waitReadyModel();

        // Random mix of commands and data with random gaps.
        for (int i = 0; i < 12; i++) begin
            r = 1'($urandom_range(0, 1));
            if (!r && $urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 2));
            else d = 8'($urandom_range(0, 255));
            hold = (i < 11) && ($urandom_range(0, 1) == 1);
            applyStimulus(r, d, hold);
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        waitReadyModel();

        // Reset asserted while E is high.
        applyStimulus(1'b1, 8'h42, 1'b0);
        waitEHigh();
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitReadyModel();

        applyStimulus(1'b1, 8'h5A, 1'b0);
        waitReadyModel();
        repeat (5) @(negedge clk);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
